uart_echo_controller: RTL and testbench

//  Top-level UART controller: receives 8N1 serial bytes on rxd, shows the last good byte on word_1,
//  and echoes received bytes on txd when switch SW is on. Also outputs freq_clk, a free-running

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_tx.sv | 98 +++++++++
 rtl/uart_echo_controller.sv | 183 ++++++++++++++++++
 tb/tb_uart_echo_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-timing derivation and the RX/TX state encodings.
package uart_pkg;

    localparam int unsigned DefaultClkFreq = 50_000_000;
    localparam int unsigned DefaultBaud    = 4800;

    // One bit time in clock cycles, truncated.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

    function automatic int unsigned half_bit(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clks_per_bit(clk_freq, baud) / 2;
    endfunction

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

    typedef enum logic [1:0] {
        TxIdle,
        TxStart,
        TxData,
        TxStop
    } tx_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 serialiser: loads a byte on start_i while idle and shifts it out LSB first on txd_o.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10416
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       txd_o
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] BitLast = CntW'(CLKS_PER_BIT - 1);

    tx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic            bit_end;

    assign bit_end = (cnt_q == BitLast);
    assign busy_o  = (state_q != TxIdle);
    assign txd_o   = txd_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        unique case (state_q)
            TxIdle: begin
                txd_d = 1'b1;
                if (start_i) begin
                    shift_d = data_i;
                    txd_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = TxStart;
                end
            end
            TxStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                    state_d = TxData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TxData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = TxStop;
                    end else begin
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TxStop: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = TxIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = TxIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= TxIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: rtl/uart_echo_controller.sv
// UART receiver with last-byte display, switch-gated echo through uart_tx, and a baud-rate
// square wave for monitoring.
module uart_echo_controller
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DefaultClkFreq,
    parameter int unsigned BAUD     = DefaultBaud
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SW,
    input  logic       rxd,
    output logic       txd,
    output logic [7:0] word_1,
    output logic       freq_clk
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned HALF_BIT     = half_bit(CLK_FREQ, BAUD);
    localparam int unsigned CntW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned HalfW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
    localparam logic [CntW-1:0]  BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]  HalfLast = CntW'(HALF_BIT - 1);
    localparam logic [HalfW-1:0] FreqLast = HalfW'(HALF_BIT - 1);

    logic             rxd_meta_q, rxd_s_q, rxd_prev_q;
    logic             sw_meta_q, sw_s_q;
    logic [HalfW-1:0] freq_cnt_q, freq_cnt_d;
    logic             freq_clk_q, freq_clk_d;

    rx_state_e        rx_state_q, rx_state_d;
    logic [CntW-1:0]  rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       word_1_q, word_1_d;
    logic             rx_done_q, rx_done_d;

    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             pend_q, pend_d;
    logic [7:0]       pend_data_q, pend_data_d;
    logic             tx_busy, tx_free, echo_new;

    assign word_1   = word_1_q;
    assign freq_clk = freq_clk_q;

    always_comb begin
        freq_cnt_d = freq_cnt_q + 1'b1;
        freq_clk_d = freq_clk_q;
        if (freq_cnt_q == FreqLast) begin
            freq_cnt_d = '0;
            freq_clk_d = ~freq_clk_q;
        end
    end

    // Each bit is sampled near its centre: HALF_BIT into the start bit, then every bit time.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        word_1_d   = word_1_q;
        rx_done_d  = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rxd_prev_q && !rxd_s_q) begin
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_state_d = rxd_s_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_s_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxIdle;
                    if (rxd_s_q) begin
                        word_1_d  = rx_shift_q;
                        rx_done_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // tx_start_q counts as busy: uart_tx only raises busy_o the cycle after it loads.
    assign tx_free  = !tx_busy && !tx_start_q;
    assign echo_new = rx_done_q && sw_s_q;

    always_comb begin
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        if (tx_free && pend_q) begin
            tx_start_d = 1'b1;
            tx_data_d  = pend_data_q;
            pend_d     = 1'b0;
        end else if (tx_free && echo_new) begin
            tx_start_d = 1'b1;
            tx_data_d  = word_1_q;
        end
        if (echo_new && !(tx_free && !pend_q)) begin
            pend_d      = 1'b1;
            pend_data_d = word_1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q  <= 1'b1;
            rxd_s_q     <= 1'b1;
            rxd_prev_q  <= 1'b1;
            sw_meta_q   <= 1'b0;
            sw_s_q      <= 1'b0;
            freq_cnt_q  <= '0;
            freq_clk_q  <= 1'b0;
            rx_state_q  <= RxIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            word_1_q    <= 8'h00;
            rx_done_q   <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
        end else begin
            rxd_meta_q  <= rxd;
            rxd_s_q     <= rxd_meta_q;
            rxd_prev_q  <= rxd_s_q;
            sw_meta_q   <= SW;
            sw_s_q      <= sw_meta_q;
            freq_cnt_q  <= freq_cnt_d;
            freq_clk_q  <= freq_clk_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            word_1_q    <= word_1_d;
            rx_done_q   <= rx_done_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk_i  (clk),
        .rst_i  (rst),
        .data_i (tx_data_q),
        .start_i(tx_start_q),
        .busy_o (tx_busy),
        .txd_o  (txd)
    );

endmodule

// File: tb/tb_uart_echo_controller.sv
// Directed bench for uart_echo_controller at a scaled-down bit time of 16 clocks.
module tb_uart_echo_controller;

    localparam int unsigned ClkFreq = 160;
    localparam int unsigned Baud    = 10;
    localparam int Cpb  = 16;
    localparam int Half = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw  = 1'b0;
    logic       rxd = 1'b1;
    logic       txd;
    logic [7:0] word_1;
    logic       freq_clk;

    always #5 clk = ~clk;

    uart_echo_controller #(
        .CLK_FREQ(ClkFreq),
        .BAUD    (Baud)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .SW      (sw),
        .rxd     (rxd),
        .txd     (txd),
        .word_1  (word_1),
        .freq_clk(freq_clk)
    );

    int         passed = 0;
    int         total = 0;
    logic [7:0] tx_q[$];
    int         runs[$];
    int         low_cycles = 0;
    int         tx_bad = 0;

    typedef struct {
        logic       sw;
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_word;
        logic       exp_echo;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller must be at a negedge; returns at a negedge with the line idle.
    task automatic send_frame(input logic [7:0] data, input logic stop);
        rxd = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (Cpb) @(negedge clk);
        end
        rxd = stop;
        repeat (Cpb) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic wait_toggle(output int n);
        logic start;
        start = freq_clk;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (freq_clk == start && n < 4 * Half);
    endtask

    // Line monitor: decodes frames at bit centres and records low-run widths.
    initial begin
        logic       prev;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            tick(1);
            if (txd == 1'b0 && prev == 1'b1) begin
                tick(Half);
                for (int i = 0; i < 8; i++) begin
                    tick(Cpb);
                    b[i] = txd;
                end
                tick(Cpb);
                if (txd == 1'b1) tx_q.push_back(b);
                else tx_bad++;
            end
            prev = txd;
        end
    end

    initial begin
        int run;
        run = 0;
        forever begin
            tick(1);
            if (txd == 1'b0) begin
                run++;
                low_cycles++;
            end else if (run != 0) begin
                runs.push_back(run);
                run = 0;
            end
        end
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       vecs[6];
        int         n;
        int         l0;
        logic [7:0] got;

        vecs[0] = '{1'b0, 8'hFF, 1'b1, 8'hFF, 1'b0};
        vecs[1] = '{1'b1, 8'h5A, 1'b1, 8'h5A, 1'b1};
        vecs[2] = '{1'b1, 8'hA5, 1'b0, 8'h5A, 1'b0};
        vecs[3] = '{1'b1, 8'h3C, 1'b1, 8'h3C, 1'b1};
        vecs[4] = '{1'b0, 8'h81, 1'b1, 8'h81, 1'b0};
        vecs[5] = '{1'b1, 8'hC3, 1'b1, 8'hC3, 1'b1};

        // Reset state and baud square wave
        repeat (5) @(posedge clk);
        #1;
        check("reset txd", txd, 1);
        check("reset word_1", word_1, 8'h00);
        check("reset freq_clk", freq_clk, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_toggle(n);
        wait_toggle(n);
        check("freq_clk half period a", n, Half);
        wait_toggle(n);
        check("freq_clk half period b", n, Half);

        // Single frames: good, frame error, echo on/off
        for (int i = 0; i < 6; i++) begin
            sw = vecs[i].sw;
            tick(4);
            l0 = low_cycles;
            @(negedge clk);
            send_frame(vecs[i].data, vecs[i].stop);
            tick(2);
            check($sformatf("word_1 vec%0d", i), word_1, vecs[i].exp_word);
            n = 0;
            while (tx_q.size() == 0 && n < 12 * Cpb) begin
                tick(1);
                n++;
            end
            if (vecs[i].exp_echo) begin
                got = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hxx;
                check($sformatf("echo byte vec%0d", i), got, vecs[i].data);
                tick(Cpb);
            end else begin
                check($sformatf("no echo frame vec%0d", i), tx_q.size(), 0);
                check($sformatf("txd idle vec%0d", i), low_cycles - l0, 0);
            end
        end

        // Short low pulse on rxd is a glitch, not a start bit
        sw = 1'b1;
        tick(4);
        l0 = low_cycles;
        @(negedge clk);
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        tick(12 * Cpb);
        check("glitch word_1", word_1, 8'hC3);
        check("glitch no echo", tx_q.size(), 0);
        check("glitch txd idle", low_cycles - l0, 0);

        // Ten back-to-back 8'hFE frames must all echo at full bit width
        tx_q.delete();
        runs.delete();
        @(negedge clk);
        for (int k = 0; k < 10; k++) send_frame(8'hFE, 1'b1);
        n = 0;
        while (tx_q.size() < 10 && n < 30 * Cpb) begin
            tick(1);
            n++;
        end
        tick(Cpb);
        check("burst word_1", word_1, 8'hFE);
        check("burst echo count", tx_q.size(), 10);
        while (tx_q.size() != 0) check("burst echo byte", tx_q.pop_front(), 8'hFE);
        check("burst low run count", runs.size(), 10);
        while (runs.size() != 0) check("burst low run width", runs.pop_front(), 2 * Cpb);
        check("tx stop bits", tx_bad, 0);

        // Reset in the middle of an echo frame
        @(negedge clk);
        send_frame(8'h80, 1'b1);
        n = 0;
        while (txd !== 1'b0 && n < 4 * Cpb) begin
            tick(1);
            n++;
        end
        check("echo started", txd, 0);
        tick(3 * Cpb);
        check("txd low before reset", txd, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("txd after reset", txd, 1);
        @(negedge clk);
        rst = 1'b0;
        l0 = low_cycles;
        check("word_1 after reset", word_1, 8'h00);
        tick(15 * Cpb);
        check("no resumed frame", low_cycles - l0, 0);
        check("txd idle after reset", txd, 1);
        tx_q.delete();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
